draw_rect_ctl: RTL and testbench

- Motion controller that drives the xpos/ypos inputs of draw_rect, so the sprite no longer takes the raw MouseCtl position.
- IDLE: the rectangle follows the mouse.
- A left click releases it: it falls under constant gravity, bounces off a floor line with damping, and comes to rest.
- A further click returns it to mouse-follow mode.
- Sits between MouseCtl and draw_rect in top_vga, in the VGA pixel-clock domain.

---
 rtl/draw_rect_ctl.sv | 154 +++++++++++++++
 tb/tb_draw_rect_ctl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_ctl.sv
// Motion controller for the draw_rect sprite: follows the mouse, or falls
// under gravity and bounces on a floor line after a left click.
`timescale 1ns / 1ps

// state | meaning
// IDLE  | rectangle follows mouse position (y clamped to floor)
// FALL  | accelerating downwards once per tick until the floor is reached
// RISE  | decelerating upwards after a bounce until velocity reaches zero
// DONE  | at rest on the floor, waiting for a click to resume mouse-follow
module draw_rect_ctl #(
  parameter int CLK_HZ  = 65_000_000,
  parameter int TICK_HZ = 100,
  parameter int FLOOR_Y = 704,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 64,
  parameter int MIN_V   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CNT_W    = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [12:0]      FLOOR_13 = 13'(FLOOR_Y);
  localparam logic [11:0]      FLOOR_12 = 12'(FLOOR_Y);
  localparam logic [11:0]      GRAV_12  = 12'(GRAVITY);
  localparam logic [12:0]      VMAX_13  = 13'(V_MAX);
  localparam logic [11:0]      MINV_12  = 12'(MIN_V);

  typedef enum logic [1:0] {IDLE, FALL, RISE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             left_d;
  logic             left_arm;
  logic             click;
  logic [11:0]      v;

  logic [12:0] y_next;
  logic [12:0] v_inc;
  logic [11:0] v_fall;
  logic [11:0] v_rise;
  logic [11:0] v_bounce;
  logic [11:0] mouse_y_clamp;

  // Free-running motion tick, independent of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == CNT_MAX);

  // left_arm blocks a click on the first cycle after reset, so a button
  // already held through reset is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_d   <= 1'b0;
      left_arm <= 1'b0;
    end else begin
      left_d   <= mouse_left;
      left_arm <= 1'b1;
    end
  end

  assign click = mouse_left & ~left_d & left_arm;

  always_comb begin
    y_next        = {1'b0, ypos} + {1'b0, v};
    v_inc         = {1'b0, v} + {1'b0, GRAV_12};
    v_fall        = (v_inc > VMAX_13) ? VMAX_13[11:0] : v_inc[11:0];
    v_rise        = (v > GRAV_12) ? (v - GRAV_12) : 12'd0;
    v_bounce      = v - (v >> 2);
    mouse_y_clamp = (mouse_ypos > FLOOR_12) ? FLOOR_12 : mouse_ypos;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      xpos  <= '0;
      ypos  <= '0;
      v     <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          xpos <= mouse_xpos;
          ypos <= mouse_y_clamp;
          if (click) begin
            state <= FALL;
            v     <= '0;
            busy  <= 1'b1;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_next >= FLOOR_13) begin
              ypos <= FLOOR_12;
              if (v_bounce < MINV_12) begin
                state <= DONE;
                v     <= '0;
                busy  <= 1'b0;
              end else begin
                state <= RISE;
                v     <= v_bounce;
              end
            end else begin
              ypos <= y_next[11:0];
              v    <= v_fall;
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (v == 12'd0) begin
              state <= FALL;
            end else if (v > ypos) begin
              // would overshoot the top edge: pin to 0 and start falling
              ypos <= '0;
              v    <= '0;
            end else begin
              ypos <= ypos - v;
              v    <= v_rise;
            end
          end
        end
        DONE: begin
          if (click) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl: a cycle-level reference model queues
// expected outputs, a negedge monitor pops and compares them.
`timescale 1ns / 1ps

module tb_draw_rect_ctl;

  localparam int DIV    = 10;
  localparam int FLOOR0 = 704;
  localparam int FLOOR1 = 4000;
  localparam int GRAV   = 1;
  localparam int VMAX   = 64;
  localparam int MINV   = 2;

  localparam int M_IDLE = 0;
  localparam int M_FALL = 1;
  localparam int M_RISE = 2;
  localparam int M_DONE = 3;

  typedef struct {
    int mode;
    int x;
    int y;
    int v;
    int cnt;
    bit lp;
  } mdl_t;

  typedef struct {
    int x;
    int y;
    int busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mx0 = '0, my0 = '0, mx1 = '0, my1 = '0;
  logic        ml0 = 1'b0, ml1 = 1'b0;
  logic [11:0] xpos0, ypos0, xpos1, ypos1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  mdl_t m0, m1;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  draw_rect_ctl #(.CLK_HZ(100), .TICK_HZ(10), .FLOOR_Y(FLOOR0), .GRAVITY(GRAV),
                  .V_MAX(VMAX), .MIN_V(MINV)) dut0 (
    .clk(clk), .rst(rst), .mouse_xpos(mx0), .mouse_ypos(my0), .mouse_left(ml0),
    .xpos(xpos0), .ypos(ypos0), .busy(busy0));

  draw_rect_ctl #(.CLK_HZ(100), .TICK_HZ(10), .FLOOR_Y(FLOOR1), .GRAVITY(GRAV),
                  .V_MAX(VMAX), .MIN_V(MINV)) dut1 (
    .clk(clk), .rst(rst), .mouse_xpos(mx1), .mouse_ypos(my1), .mouse_left(ml1),
    .xpos(xpos1), .ypos(ypos1), .busy(busy1));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the previous button level is treated as "pressed" after
  // reset so that only a press seen entirely after reset counts.
  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.x = 0; m.y = 0; m.v = 0; m.cnt = 0; m.lp = 1'b1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int floor_y, int mx, int my, bit ml);
    bit tick, click;
    int yn, vb;
    tick  = (m.cnt == DIV - 1);
    m.cnt = tick ? 0 : m.cnt + 1;
    click = ml && !m.lp;
    m.lp  = ml;
    if (m.mode == M_IDLE) begin
      m.x = mx;
      m.y = (my < floor_y) ? my : floor_y;
      if (click) begin m.mode = M_FALL; m.v = 0; end
    end else if (m.mode == M_FALL && tick) begin
      yn = m.y + m.v;
      if (yn >= floor_y) begin
        m.y = floor_y;
        vb  = m.v - m.v / 4;
        if (vb < MINV) begin m.mode = M_DONE; m.v = 0; end
        else begin m.mode = M_RISE; m.v = vb; end
      end else begin
        m.y = yn;
        m.v = (m.v + GRAV < VMAX) ? m.v + GRAV : VMAX;
      end
    end else if (m.mode == M_RISE && tick) begin
      if (m.v == 0) m.mode = M_FALL;
      else if (m.v > m.y) begin m.y = 0; m.v = 0; end
      else begin
        m.y = m.y - m.v;
        m.v = (m.v > GRAV) ? m.v - GRAV : 0;
      end
    end else if (m.mode == M_DONE && click) begin
      m.mode = M_IDLE;
    end
    return m;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.x = m.x; e.y = m.y;
    e.busy = (m.mode == M_FALL || m.mode == M_RISE) ? 1 : 0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end else begin
      m0 = mdl_step(m0, FLOOR0, int'(mx0), int'(my0), ml0);
      m1 = mdl_step(m1, FLOOR1, int'(mx1), int'(my1), ml1);
    end
    q0.push_back(to_exp(m0));
    q1.push_back(to_exp(m1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      chk("rst_x0", int'(xpos0), 0);
      chk("rst_y0", int'(ypos0), 0);
      chk("rst_busy0", int'(busy0), 0);
      chk("rst_y1", int'(ypos1), 0);
    end else begin
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("sb_x0", int'(xpos0), e0.x);
        chk("sb_y0", int'(ypos0), e0.y);
        chk("sb_busy0", int'(busy0), e0.busy);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("sb_x1", int'(xpos1), e1.x);
        chk("sb_y1", int'(ypos1), e1.y);
        chk("sb_busy1", int'(busy1), e1.busy);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_y0(input int target, input int budget, input string name);
    int k = 0;
    while (int'(ypos0) != target && k < budget) begin cyc(1); k++; end
    chk(name, int'(ypos0), target);
    chk({name, "_busy"}, int'(busy0), 1);
    chk({name, "_x"}, int'(xpos0), 50);
  endtask

  task automatic wait_y1(input int target, input int budget, input string name);
    int k = 0;
    while (int'(ypos1) != target && k < budget) begin cyc(1); k++; end
    chk(name, int'(ypos1), target);
  endtask

  task automatic wait_busy0(input logic val, input int budget, input string name);
    int k = 0;
    while (busy0 != val && k < budget) begin cyc(1); k++; end
    chk(name, int'(busy0), int'(val));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    m0 = mdl_reset();
    m1 = mdl_reset();

    // Reset and mouse-follow
    mx0 = 12'd300; my0 = 12'd400;
    #1 rst = 1'b0;
    #1;
    chk("t1_rst_x", int'(xpos0), 0);
    chk("t1_rst_y", int'(ypos0), 0);
    chk("t1_rst_busy", int'(busy0), 0);
    cyc(2);
    mx0 = 12'd100; my0 = 12'd200;
    rst = 1'b1;
    cyc(1);
    chk("t1_follow_x", int'(xpos0), 100);
    chk("t1_follow_y", int'(ypos0), 200);
    my0 = 12'd900;
    cyc(1);
    chk("t1_clamp_y", int'(ypos0), 704);

    // Fall and bounce
    mx0 = 12'd50; my0 = 12'd700;
    cyc(1);
    ml0 = 1'b1;
    cyc(1);
    chk("t2_click_busy", int'(busy0), 1);
    chk("t2_click_y", int'(ypos0), 700);
    ml0 = 1'b0;
    mx0 = 12'd999; my0 = 12'd5;
    wait_y0(701, 25, "t2_y701");
    wait_y0(703, 15, "t2_y703");
    wait_y0(704, 15, "t2_y704");
    wait_y0(701, 15, "t2_r701");
    wait_y0(699, 15, "t2_r699");
    wait_y0(698, 15, "t2_r698");
    wait_y0(699, 35, "t2_f699");
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) ml0 = ~ml0;
      cyc(1);
    end
    ml0 = 1'b0;
    chk("t4_toggle_busy", int'(busy0), 1);
    chk("t4_toggle_x", int'(xpos0), 50);

    // Reset mid-RISE, between clock edges
    k = 0;
    while (m0.mode != M_RISE && k < 200) begin cyc(1); k++; end
    chk("t5_rise_reached", int'(k < 200), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_x", int'(xpos0), 0);
    chk("t5_async_y", int'(ypos0), 0);
    chk("t5_async_busy", int'(busy0), 0);
    cyc(2);
    mx0 = 12'd20; my0 = 12'd704;
    rst = 1'b1;
    cyc(1);
    chk("t5_follow_x", int'(xpos0), 20);
    chk("t5_follow_y", int'(ypos0), 704);

    // Stop on floor, then return to mouse-follow
    ml0 = 1'b1;
    cyc(1);
    ml0 = 1'b0;
    chk("t3_fall_busy", int'(busy0), 1);
    wait_busy0(1'b0, 25, "t3_done_busy");
    chk("t3_done_y", int'(ypos0), 704);
    mx0 = 12'd10; my0 = 12'd10;
    cyc(5);
    chk("t3_hold_x", int'(xpos0), 20);
    chk("t3_hold_y", int'(ypos0), 704);
    ml0 = 1'b1;
    cyc(1);
    chk("t3_click_x", int'(xpos0), 20);
    cyc(1);
    chk("t3_reload_x", int'(xpos0), 10);
    chk("t3_reload_y", int'(ypos0), 10);
    ml0 = 1'b0;
    cyc(1);

    // Click coinciding with a tick, button held 50 cycles
    k = 0;
    while (m0.cnt != DIV - 1 && k < 20) begin cyc(1); k++; end
    mx0 = 12'd123; my0 = 12'd321;
    ml0 = 1'b1;
    cyc(1);
    chk("t4_tick_click_busy", int'(busy0), 1);
    chk("t4_tick_click_y", int'(ypos0), 321);
    chk("t4_tick_click_x", int'(xpos0), 123);
    cyc(5);
    chk("t4_no_motion_y", int'(ypos0), 321);
    cyc(44);
    chk("t4_held_busy", int'(busy0), 1);
    ml0 = 1'b0;
    cyc(3);

    // Velocity saturation on the tall-floor instance
    mx1 = 12'd7; my1 = 12'd0;
    cyc(1);
    ml1 = 1'b1;
    cyc(1);
    ml1 = 1'b0;
    chk("t6_busy1", int'(busy1), 1);
    wait_y1(2080, 800, "t6_y2080");
    wait_y1(2144, 15, "t6_y2144");
    wait_y1(2208, 15, "t6_y2208");
    chk("t6_x1", int'(xpos1), 7);

    // Button held through reset release is not a click
    ml0 = 1'b1;
    #2 rst = 1'b0;
    cyc(2);
    mx0 = 12'd55; my0 = 12'd66;
    rst = 1'b1;
    cyc(20);
    chk("t7_no_click_busy", int'(busy0), 0);
    chk("t7_follow_y", int'(ypos0), 66);
    ml0 = 1'b0;
    cyc(1);
    ml0 = 1'b1;
    cyc(1);
    chk("t7_click_busy", int'(busy0), 1);
    ml0 = 1'b0;

    // Randomized phase, checked by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mx0 = 12'($urandom_range(0, 1023));
        my0 = 12'($urandom_range(0, 1000));
        mx1 = 12'($urandom_range(0, 1023));
        my1 = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 29) == 0) ml0 = ~ml0;
      if ($urandom_range(0, 29) == 0) ml1 = ~ml1;
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b0;
        cyc(2);
        rst = 1'b1;
      end
      cyc(1);
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
